// File: rtl/vga_pkg.sv
// Shared VGA display constants, the RGB332 pixel type and the scan-fetch FSM encoding.
package vga_pkg;

  typedef logic [7:0] rgb332_t;

  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;
  localparam int BPP      = 8;

  // 32-bit framebuffer words needed to cover one active scanline
  localparam int DEF_WORDS_PER_LINE = H_ACTIVE * BPP / 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/sync_fifo_w32.sv
// 32-bit synchronous show-ahead FIFO with flush, occupancy count and same-cycle read+write.
// DEPTH must be a power of two; pointers wrap naturally.
module sync_fifo_w32 #(
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  output logic [31:0]   rd_data,
  output logic [CW-1:0] used,
  output logic          full,
  output logic          empty
);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_wr, do_rd;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign do_rd = rd_en & ~empty;
  // a full FIFO still accepts a write when a read frees the slot in the same cycle
  assign do_wr = wr_en & (~full | do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_wr);
    rd_ptr_d = rd_ptr_q + AW'(do_rd);
    cnt_d    = cnt_q + CW'(do_wr) - CW'(do_rd);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign used    = cnt_q;

endmodule

// File: rtl/vram_scan_fetch.sv
// Framebuffer prefetch: credit-limited word reads from the ExtRAM arbiter into a FIFO,
// unpacked into RGB332 pixels byte 0 first for the VGA pipeline.
module vram_scan_fetch
  import vga_pkg::*;
#(
  parameter logic [19:0] FB_BASE        = 20'h00000,
  parameter int          WORDS_PER_LINE = DEF_WORDS_PER_LINE,
  parameter int          LINES          = V_ACTIVE,
  parameter int          FIFO_DEPTH     = 64
) (
  input  logic        aclk,
  input  logic        areset,
  input  logic        frame_start,
  output logic        mem_req,
  output logic [19:0] mem_addr,
  input  logic        mem_gnt,
  input  logic [31:0] mem_rdata,
  input  logic        pix_pop,
  output logic        pix_valid,
  output logic [7:0]  pix_data,
  output logic        frame_done,
  output logic        underflow,
  output logic [15:0] underflow_cnt
);

  localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [16:0] LAST_WORD = 17'(WORDS_PER_LINE * LINES - 1);
  localparam logic [CW:0] DEPTH_L   = (CW + 1)'(FIFO_DEPTH);

  logic [1:0]    state_q, state_d;
  logic [19:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [16:0]   wcnt_q, wcnt_d;
  logic          inflight_q, inflight_d;
  logic [31:0]   word_q, word_d;
  logic [1:0]    idx_q, idx_d;
  logic          vld_q, vld_d;
  logic          uf_q, uf_d;
  logic [15:0]   ufcnt_q, ufcnt_d;

  logic          grant;
  logic          fifo_wr, fifo_rd;
  logic [31:0]   fifo_rdata;
  logic [CW-1:0] fifo_used;
  logic          fifo_full, fifo_empty;
  logic          consume, last_byte;
  logic [CW-1:0] used_nxt;
  logic [CW:0]   occ_d;
  rgb332_t       cur_pix;

  assign grant     = req_q & mem_gnt;
  // a return landing in the frame_start cycle belongs to the old frame
  assign fifo_wr   = inflight_q & ~frame_start;
  assign consume   = pix_pop & vld_q;
  assign last_byte = consume & (idx_q == 2'd3);
  assign fifo_rd   = (~vld_q | last_byte) & ~fifo_empty & ~frame_start;

  sync_fifo_w32 #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (aclk),
    .rst     (areset),
    .flush   (frame_start),
    .wr_en   (fifo_wr),
    .wr_data (mem_rdata),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .used    (fifo_used),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wcnt_d     = wcnt_q;
    inflight_d = grant;
    if (frame_start) begin
      state_d    = ST_FETCH;
      addr_d     = FB_BASE;
      wcnt_d     = '0;
      inflight_d = 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (grant) begin
            addr_d = addr_q + 20'd1;
            wcnt_d = wcnt_q + 17'd1;
            if (wcnt_q == LAST_WORD) state_d = ST_DONE;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    word_d = word_q;
    idx_d  = idx_q;
    vld_d  = vld_q;
    if (frame_start) begin
      vld_d = 1'b0;
      idx_d = 2'd0;
    end else if (fifo_rd) begin
      word_d = fifo_rdata;
      idx_d  = 2'd0;
      vld_d  = 1'b1;
    end else if (last_byte) begin
      vld_d = 1'b0;
      idx_d = 2'd0;
    end else if (consume) begin
      idx_d = idx_q + 2'd1;
    end
  end

  // Credit covers FIFO, output stage and the in-flight word so the stage cannot be overrun
  always_comb begin
    used_nxt = frame_start ? '0 : (fifo_used + CW'(fifo_wr) - CW'(fifo_rd));
    occ_d    = {1'b0, used_nxt} + (CW + 1)'(vld_d) + (CW + 1)'(inflight_d);
    req_d    = (state_d == ST_FETCH) && (occ_d < DEPTH_L);
  end

  always_comb begin
    uf_d    = pix_pop & ~vld_q;
    ufcnt_d = ufcnt_q;
    if (uf_d && ufcnt_q != 16'hFFFF) ufcnt_d = ufcnt_q + 16'd1;
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      addr_q     <= FB_BASE;
      req_q      <= 1'b0;
      wcnt_q     <= '0;
      inflight_q <= 1'b0;
      word_q     <= '0;
      idx_q      <= 2'd0;
      vld_q      <= 1'b0;
      uf_q       <= 1'b0;
      ufcnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      req_q      <= req_d;
      wcnt_q     <= wcnt_d;
      inflight_q <= inflight_d;
      word_q     <= word_d;
      idx_q      <= idx_d;
      vld_q      <= vld_d;
      uf_q       <= uf_d;
      ufcnt_q    <= ufcnt_d;
    end
  end

  assign cur_pix       = word_q[{idx_q, 3'b000} +: 8];
  assign mem_req       = req_q;
  assign mem_addr      = addr_q;
  assign pix_valid     = vld_q;
  assign pix_data      = vld_q ? cur_pix : 8'h00;
  assign frame_done    = (state_q == ST_DONE);
  assign underflow     = uf_q;
  assign underflow_cnt = ufcnt_q;

endmodule

// File: tb/tb_vram_scan_fetch.sv
// Directed bench for vram_scan_fetch with a small ExtRAM model returning word data one cycle after grant.
module tb_vram_scan_fetch;

  localparam logic [19:0] BASE  = 20'h00400;
  localparam int          WPL   = 160;
  localparam int          LN    = 4;
  localparam int          DEPTH = 64;
  localparam int          TOTAL = WPL * LN;

  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        frame_start = 1'b0;
  logic        mem_gnt = 1'b0;
  logic        pix_pop = 1'b0;
  logic [31:0] mem_rdata = 32'hDEADBEEF;
  logic        mem_req;
  logic [19:0] mem_addr;
  logic        pix_valid;
  logic [7:0]  pix_data;
  logic        frame_done;
  logic        underflow;
  logic [15:0] underflow_cnt;

  vram_scan_fetch #(
    .FB_BASE(BASE), .WORDS_PER_LINE(WPL), .LINES(LN), .FIFO_DEPTH(DEPTH)
  ) dut (
    .aclk(aclk), .areset(areset), .frame_start(frame_start),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rdata(mem_rdata),
    .pix_pop(pix_pop), .pix_valid(pix_valid), .pix_data(pix_data),
    .frame_done(frame_done), .underflow(underflow), .underflow_cnt(underflow_cnt)
  );

  always #5 aclk = ~aclk;

  int          checks = 0;
  int          failures = 0;
  int          grants, gaps, pix_cnt, pix_err, uf_seen;
  logic [19:0] exp_addr, last_addr;
  logic [7:0]  popped[$];

  // memory image: byte j of word k (relative to BASE) is 8'h11*(j+1) + k
  function automatic logic [31:0] word_of(logic [19:0] a);
    logic [7:0]  k;
    logic [31:0] w;
    k = 8'(a - BASE);
    for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(17 * (j + 1)) + k;
    return w;
  endfunction

  function automatic logic [7:0] pix_exp(int n);
    logic [31:0] w;
    w = word_of(BASE + 20'(n / 4));
    return w[(n % 4) * 8 +: 8];
  endfunction

  task automatic step();
    logic        g;
    logic [19:0] a;
    g = mem_req & mem_gnt;
    a = mem_addr;
    if (pix_pop && pix_valid) begin
      if (pix_data !== pix_exp(pix_cnt)) pix_err++;
      popped.push_back(pix_data);
      pix_cnt++;
    end
    @(posedge aclk);
    #1;
    mem_rdata = g ? word_of(a) : 32'hDEADBEEF;
    if (g) begin
      if (a !== exp_addr) gaps++;
      exp_addr  = a + 20'd1;
      last_addr = a;
      grants++;
    end
    if (underflow) uf_seen++;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    grants = 0; gaps = 0; exp_addr = BASE; last_addr = '0;
    pix_cnt = 0; pix_err = 0; popped.delete();
  endtask

  task automatic test_reset();
    step(); step();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req got=%0b exp=0", mem_req); end
    checks++; if (mem_addr !== BASE) begin failures++; $display("FAIL reset_mem_addr got=%0h exp=%0h", mem_addr, BASE); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL reset_pix_valid got=%0b exp=0", pix_valid); end
    checks++; if (pix_data !== 8'h00) begin failures++; $display("FAIL reset_pix_data got=%0h exp=0", pix_data); end
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL reset_frame_done got=%0b exp=0", frame_done); end
    checks++; if (underflow !== 1'b0) begin failures++; $display("FAIL reset_underflow got=%0b exp=0", underflow); end
    checks++; if (underflow_cnt !== 16'h0) begin failures++; $display("FAIL reset_uf_cnt got=%0h exp=0", underflow_cnt); end
    areset = 1'b0;
    step(); step();
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL idle_mem_req got=%0b exp=0", mem_req); end
  endtask

  task automatic test_credit();
    mem_gnt = 1'b1; pix_pop = 1'b0;
    pulse_start();
    repeat (100) step();
    checks++; if (grants != 64) begin failures++; $display("FAIL credit_grants got=%0d exp=64", grants); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL credit_addr_gaps got=%0d exp=0", gaps); end
    checks++; if (last_addr !== 20'h0043F) begin failures++; $display("FAIL credit_last_addr got=%0h exp=43f", last_addr); end
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL credit_req_off got=%0b exp=0", mem_req); end
    checks++; if (pix_valid !== 1'b1) begin failures++; $display("FAIL credit_pix_valid got=%0b exp=1", pix_valid); end
    checks++; if (pix_data !== 8'h11) begin failures++; $display("FAIL credit_pix_data got=%0h exp=11", pix_data); end
  endtask

  task automatic test_unpack();
    logic [7:0] exp5 [5];
    exp5 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h12};
    uf_seen = 0;
    pix_pop = 1'b1;
    repeat (12) step();
    pix_pop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (popped.size() <= i || popped[i] !== exp5[i]) begin
        failures++;
        $display("FAIL unpack_pix%0d got=%0h exp=%0h", i, (popped.size() > i) ? popped[i] : 8'hxx, exp5[i]);
      end
    end
    checks++; if (popped.size() != 12) begin failures++; $display("FAIL unpack_no_bubble got=%0d pixels exp=12", popped.size()); end
    checks++; if (pix_err != 0) begin failures++; $display("FAIL unpack_pix_errors got=%0d exp=0", pix_err); end
    checks++; if (uf_seen != 0) begin failures++; $display("FAIL unpack_underflow got=%0d exp=0", uf_seen); end
  endtask

  task automatic test_stall();
    int stall_bad;
    mem_gnt = 1'b0; pix_pop = 1'b0;
    pulse_start();
    mem_gnt = 1'b1;
    repeat (5) step();
    mem_gnt = 1'b0;
    stall_bad = 0;
    repeat (20) begin
      step();
      if (!(mem_req === 1'b1 && mem_addr === 20'h00405)) stall_bad++;
    end
    mem_gnt = 1'b1;
    repeat (10) step();
    mem_gnt = 1'b0;
    checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_hold got=%0d unstable cycles exp=0", stall_bad); end
    checks++; if (grants != 15) begin failures++; $display("FAIL stall_grants got=%0d exp=15", grants); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL stall_addr_gaps got=%0d exp=0", gaps); end
    checks++; if (last_addr !== 20'h0040E) begin failures++; $display("FAIL stall_last_addr got=%0h exp=40e", last_addr); end
  endtask

  task automatic test_full_frame();
    int  req_after_done;
    bit  done_seen;
    mem_gnt = 1'b0; pix_pop = 1'b0;
    pulse_start();
    mem_gnt = 1'b1;
    req_after_done = 0; done_seen = 0;
    for (int i = 0; i < 6000 && pix_cnt < 4 * TOTAL; i++) begin
      pix_pop = pix_valid;
      step();
      if (frame_done) done_seen = 1;
      if (done_seen && mem_req) req_after_done++;
    end
    pix_pop = 1'b0;
    repeat (5) begin
      step();
      if (mem_req) req_after_done++;
    end
    checks++; if (pix_cnt != 2560) begin failures++; $display("FAIL frame_pixels got=%0d exp=2560", pix_cnt); end
    checks++; if (grants != 640) begin failures++; $display("FAIL frame_grants got=%0d exp=640", grants); end
    checks++; if (last_addr !== 20'h0067F) begin failures++; $display("FAIL frame_last_addr got=%0h exp=67f", last_addr); end
    checks++; if (gaps != 0) begin failures++; $display("FAIL frame_addr_gaps got=%0d exp=0", gaps); end
    checks++; if (frame_done !== 1'b1) begin failures++; $display("FAIL frame_done got=%0b exp=1", frame_done); end
    checks++; if (req_after_done != 0) begin failures++; $display("FAIL frame_req_after_done got=%0d exp=0", req_after_done); end
    checks++; if (pix_err != 0) begin failures++; $display("FAIL frame_pix_errors got=%0d exp=0", pix_err); end
    checks++; if (underflow_cnt !== 16'h0) begin failures++; $display("FAIL frame_uf_cnt got=%0h exp=0", underflow_cnt); end
    mem_gnt = 1'b0;
    pulse_start();
    checks++; if (frame_done !== 1'b0) begin failures++; $display("FAIL restart_done_drop got=%0b exp=0", frame_done); end
    checks++; if (mem_addr !== BASE) begin failures++; $display("FAIL restart_done_addr got=%0h exp=%0h", mem_addr, BASE); end
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL restart_done_req got=%0b exp=1", mem_req); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL restart_done_valid got=%0b exp=0", pix_valid); end
  endtask

  task automatic test_restart();
    bit found;
    mem_gnt = 1'b1; pix_pop = 1'b0;
    pulse_start();
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      step();
      if (grants > 0 && last_addr === 20'h00425) found = 1;
    end
    checks++; if (!found) begin failures++; $display("FAIL restart_grant37 got=not_seen exp=seen"); end
    pulse_start();
    mem_gnt = 1'b0;
    repeat (3) step();
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL restart_dropped got_valid=%0b exp=0", pix_valid); end
    checks++; if (mem_addr !== BASE) begin failures++; $display("FAIL restart_addr got=%0h exp=%0h", mem_addr, BASE); end
    checks++; if (mem_req !== 1'b1) begin failures++; $display("FAIL restart_req got=%0b exp=1", mem_req); end
    mem_gnt = 1'b1;
    for (int i = 0; i < 20 && !pix_valid; i++) step();
    mem_gnt = 1'b0;
    checks++; if (gaps != 0 || grants == 0) begin failures++; $display("FAIL restart_first_addr gaps=%0d grants=%0d exp gaps=0", gaps, grants); end
    checks++; if (pix_valid !== 1'b1) begin failures++; $display("FAIL restart_valid got=%0b exp=1", pix_valid); end
    checks++; if (pix_data !== 8'h11) begin failures++; $display("FAIL restart_first_pix got=%0h exp=11", pix_data); end
  endtask

  task automatic test_underflow();
    mem_gnt = 1'b0; pix_pop = 1'b0;
    pulse_start();
    checks++; if (underflow_cnt !== 16'h0) begin failures++; $display("FAIL uf_start_cnt got=%0h exp=0", underflow_cnt); end
    uf_seen = 0;
    repeat (3) begin
      pix_pop = 1'b1; step();
      pix_pop = 1'b0; step();
    end
    step();
    checks++; if (uf_seen != 3) begin failures++; $display("FAIL uf_pulses got=%0d exp=3", uf_seen); end
    checks++; if (underflow_cnt !== 16'd3) begin failures++; $display("FAIL uf_cnt3 got=%0h exp=3", underflow_cnt); end
    checks++; if (pix_data !== 8'h00) begin failures++; $display("FAIL uf_pix_data got=%0h exp=0", pix_data); end
    pix_pop = 1'b1;
    repeat (65540) step();
    pix_pop = 1'b0;
    step();
    checks++; if (underflow_cnt !== 16'hFFFF) begin failures++; $display("FAIL uf_saturate got=%0h exp=ffff", underflow_cnt); end
  endtask

  task automatic test_reset_mid();
    mem_gnt = 1'b1; pix_pop = 1'b0;
    pulse_start();
    repeat (10) step();
    #2 areset = 1'b1;
    #1;
    checks++; if (mem_req !== 1'b0) begin failures++; $display("FAIL arst_mem_req got=%0b exp=0", mem_req); end
    checks++; if (mem_addr !== BASE) begin failures++; $display("FAIL arst_mem_addr got=%0h exp=%0h", mem_addr, BASE); end
    checks++; if (pix_valid !== 1'b0) begin failures++; $display("FAIL arst_pix_valid got=%0b exp=0", pix_valid); end
    checks++; if (underflow_cnt !== 16'h0) begin failures++; $display("FAIL arst_uf_cnt got=%0h exp=0", underflow_cnt); end
    @(posedge aclk);
    #1 areset = 1'b0;
    step(); step();
    mem_gnt = 1'b0;
    checks++; if (mem_req !== 1'b0 || pix_valid !== 1'b0) begin failures++; $display("FAIL arst_idle req=%0b valid=%0b exp 0/0", mem_req, pix_valid); end
  endtask

  initial begin
    test_reset();
    test_credit();
    test_unpack();
    test_stall();
    test_full_frame();
    test_restart();
    test_underflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
